// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: turns single commands into one AHB-Lite NONSEQ transfer each.
// A command is accepted in IDLE; an aligned command runs ADDR -> DATA -> RSP,
// a misaligned or oversize one goes straight to RSP with an error and no bus
// activity. Every output comes straight from a flop, so each *_d value is
// computed from the next state rather than the current one.
module ahb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [2:0]            cmd_size,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [15:0]           xfer_cnt,
  output logic                  hsel,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hresp
);

  localparam logic [2:0] MAX_SIZE     = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
  localparam logic [1:0] HTRANS_IDLE  = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [15:0]             xfer_cnt_q, xfer_cnt_d;
  logic                    hsel_q, hsel_d;
  logic [1:0]              htrans_q, htrans_d;
  logic                    hwrite_q, hwrite_d;
  logic [2:0]              hsize_q, hsize_d;
  logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
  logic [DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
  // Command latch: only meaningful between acceptance and RSP, so left unreset.
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                    accept;
  logic                    aligned;
  logic [ADDR_WIDTH-1:0]   align_mask;

  // Alignment/size legality of the command currently offered.
  always_comb begin
    align_mask = ~({ADDR_WIDTH{1'b1}} << cmd_size);
    aligned    = (cmd_size <= MAX_SIZE) && ((cmd_addr & align_mask) == '0);
    accept     = cmd_valid && cmd_ready_q;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    xfer_cnt_d  = xfer_cnt_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    haddr_d     = haddr_q;
    hwdata_d    = hwdata_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = cmd_write;
          wdata_d = cmd_wdata;
          if (aligned) begin
            state_d  = S_ADDR;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
          end else begin
            state_d   = S_RSP;
            rsp_err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (hready) begin
          state_d = S_DATA;
          if (wr_q) hwdata_d = wdata_q;
        end
      end
      S_DATA: begin
        // hresp=1 with hready=0 is the first ERROR cycle: just another wait.
        if (hready) begin
          state_d     = S_RSP;
          xfer_cnt_d  = xfer_cnt_q + 16'd1;
          rsp_err_d   = hresp;
          rsp_rdata_d = (!wr_q && !hresp) ? hrdata : '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    hsel_d      = (state_d == S_ADDR);
    htrans_d    = (state_d == S_ADDR) ? HTRANS_NSEQ : HTRANS_IDLE;
    rsp_valid_d = (state_d == S_RSP);
  end

  // State and output registers, cleared asynchronously by hresetn.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      xfer_cnt_q  <= '0;
      hsel_q      <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      xfer_cnt_q  <= xfer_cnt_d;
      hsel_q      <= hsel_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      haddr_q     <= haddr_d;
      hwdata_q    <= hwdata_d;
    end
  end

  // Command latch registers.
  always_ff @(posedge hclk) begin
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign hsel      = hsel_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign haddr     = haddr_q;
  assign hwdata    = hwdata_q;

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the AHB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the AHB data width; legal values are 32 and 64.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, per these port lines:
  hclk  input  1  single clock; all state updates on rising edge.
  hresetn  input  1  asynchronous active-low reset.
  cmd_valid  input  1  command offered.
  cmd_ready  output  1  command accepted when high together with cmd_valid.
  cmd_write  input  1  1=write, 0=read.
  cmd_addr  input  ADDR_WIDTH  byte address.
  cmd_wdata  input  DATA_WIDTH  write data.
  cmd_size  input  3  HSIZE encoding.
  rsp_valid  output  1  one-cycle completion pulse.
  rsp_rdata  output  DATA_WIDTH  captured read data (0 for writes and errors).
  rsp_err  output  1  completion was a slave ERROR or an alignment reject.
  xfer_cnt  output  16  completed bus transfers.
  hsel  output  1  slave select.
  htrans  output  2  IDLE=2'b00, NONSEQ=2'b10 only.
  hwrite  output  1  transfer direction.
  hsize  output  3  transfer size.
  haddr  output  ADDR_WIDTH  transfer address.
  hwdata  output  DATA_WIDTH  write data in the data phase.
  hready  input  1  slave HREADYOUT.
  hrdata  input  DATA_WIDTH  slave read data.
  hresp  input  1  slave response, 1=ERROR.

Function
REQ-004 The block SHALL implement FSM states IDLE, ADDR, DATA and RSP, with all outputs registered.
REQ-005 In IDLE with cmd_valid=1 and cmd_ready=1, the block SHALL latch cmd_write, cmd_addr, cmd_wdata and cmd_size.
REQ-006 After the REQ-005 latch, the next state SHALL be ADDR if the command is aligned and legal, else RSP.
REQ-007 A command SHALL be an alignment reject if cmd_size > log2(DATA_WIDTH/8) or cmd_addr is not a multiple of 2^cmd_size; a reject SHALL issue no bus transfer and SHALL give rsp_err=1.
REQ-008 In ADDR the block SHALL drive hsel=1, htrans=NONSEQ and the latched haddr/hwrite/hsize.
REQ-009 In ADDR the block SHALL move to DATA on a cycle with hready=1 and SHALL hold every address-phase signal stable while hready=0.
REQ-010 In DATA the block SHALL drive hsel=0 and htrans=IDLE, and SHALL drive hwdata with the latched write data for writes.
REQ-011 In DATA the block SHALL stay in DATA while hready=0.
REQ-012 On the DATA cycle with hready=1, the block SHALL capture hrdata (reads only) and hresp, and SHALL move to RSP.
REQ-013 The first cycle of a two-cycle ERROR response (hresp=1, hready=0) SHALL be treated as a wait state.
REQ-014 In RSP the block SHALL assert rsp_valid for exactly one cycle with the captured rsp_rdata/rsp_err, then return to IDLE.
REQ-015 rsp_rdata SHALL be 0 for writes and for any rsp_err=1 completion.
REQ-016 cmd_ready SHALL be high exactly when the state is IDLE, so it is low from acceptance through the RSP cycle.
REQ-017 Latency with zero wait states SHALL be: accept at cycle T, ADDR at T+1, DATA at T+2, rsp_valid at T+3, cmd_ready=1 at T+4; each wait state adds one cycle.
REQ-018 An alignment reject SHALL give rsp_valid at T+1.
REQ-019 haddr, hwrite, hsize and hwdata SHALL hold their last values outside ADDR/DATA; hsel/htrans SHALL be 0/IDLE outside ADDR.
REQ-020 xfer_cnt SHALL increment by 1 on each completed data phase (including hresp ERROR), SHALL not count alignment rejects, and SHALL wrap 0xFFFF -> 0x0000.
REQ-021 There is no rsp backpressure; rsp_valid SHALL never stall the FSM.
REQ-022 cmd_* inputs outside an accepting cycle SHALL be ignored.

Reset
REQ-023 While hresetn=0 the block SHALL force state=IDLE immediately, independent of hclk.
REQ-024 While hresetn=0 all outputs SHALL be 0: cmd_ready, rsp_valid, rsp_rdata, rsp_err, xfer_cnt, hsel, htrans, hwrite, hsize, haddr and hwdata.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer with no rsp_valid.
REQ-026 cmd_ready SHALL first rise on the first hclk edge after hresetn deasserts.

Verification
REQ-027 Write, zero wait: cmd addr=0x10, wdata=0xA5A5_0001, size=2 -> haddr=0x10, htrans=2'b10 for 1 cycle; next cycle hwdata=0xA5A5_0001; rsp_valid at T+3, rsp_err=0; xfer_cnt=1.
REQ-028 Read with 3 wait states, hrdata=0x1234_5678: htrans returns to IDLE after the address phase; rsp_valid at T+6 with rsp_rdata=0x1234_5678.
REQ-029 ERROR response (hresp=1/hready=0, then hresp=1/hready=1): rsp_err=1, rsp_rdata=0, xfer_cnt increments.
REQ-030 Misaligned command (addr=0x2, size=2) or size=3 with DATA_WIDTH=32: hsel never asserts, rsp_valid at T+1 with rsp_err=1, xfer_cnt unchanged.
REQ-031 Counter wrap: preload 65535 transfers, then one more -> xfer_cnt=0x0000.
REQ-032 hresetn pulsed low during DATA: all outputs 0 within the reset pulse, no rsp_valid, cmd_ready=1 on the first edge after release.
